fpu_issue_ctrl: RTL and testbench
=================================

FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 4, max FPU ops issued but not yet written back (range 1..15).
REQ-002 SHALL have ports clk  in  1  system clock, rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port id_valid  in  1  decoded FPU op present.
REQ-005 SHALL have ports id_op  in  FPUOper_t; id_raddr1, id_raddr2  in  5; id_we  in  1; id_waddr  in  5, all as produced by the FPU decoder.
REQ-006 SHALL have port id_ready  out  1  op accepted this cycle when id_valid && id_ready.
REQ-007 SHALL have port flush  in  1  drop the not-yet-issued op.
REQ-008 SHALL have ports iss_valid  out  1; iss_op  out  FPUOper_t; iss_raddr1, iss_raddr2  out  5; iss_we  out  1; iss_waddr  out  5; iss_ready  in  1.
REQ-009 SHALL have ports wb_valid  in  1  one op completed; wb_we  in  1  completion wrote a register; wb_addr  in  5  written register.
REQ-010 SHALL have ports pending  out  32  scoreboard, bit i = write to f(i) outstanding; busy  out  1  slot full or inflight != 0.

Function
REQ-011 SHALL hold one issue slot with states EMPTY and FULL.
REQ-012 Hazard SHALL be pending[id_raddr1] | pending[id_raddr2] | (id_we & pending[id_waddr]); index 0 SHALL be checked like every other index.
REQ-013 id_ready SHALL be !hazard && !flush && (slot EMPTY || iss fires this cycle).
REQ-014 On accept, the slot SHALL capture all id_* fields and go FULL; pending[id_waddr] SHALL set next cycle when id_we=1.
REQ-015 iss_valid SHALL be slot FULL && inflight < MAX_INFLIGHT; it SHALL NOT depend on iss_ready.
REQ-016 iss_* SHALL be driven from slot registers only; earliest iss_valid is the cycle after accept (latency 1).
REQ-017 Issue fires on iss_valid && iss_ready; slot SHALL go EMPTY unless a new op is accepted in the same cycle (back-to-back, 1 op/cycle).
REQ-018 inflight SHALL be a 4-bit counter: +1 on issue fire, -1 on wb_valid, unchanged when both occur.
REQ-019 wb_valid with inflight=0 is illegal; counter SHALL hold at 0 and a simulation assertion SHALL fire.
REQ-020 wb_valid && wb_we SHALL clear pending[wb_addr]; a same-cycle set to the same index SHALL win.
REQ-021 Op with id_we=0 SHALL still count in inflight and require a wb_valid with wb_we=0.
REQ-022 flush SHALL empty the slot if FULL and not firing this cycle, clear pending[slot waddr] if slot we=1, and leave inflight and other pending bits unchanged.
REQ-023 flush in the cycle the slot issues SHALL NOT cancel the issued op.
REQ-024 Once iss_valid is high, iss_* SHALL remain stable until fire or flush.

Reset
REQ-025 On rst, SHALL set slot EMPTY, inflight=0, pending=0; outputs SHALL read iss_valid=0, id_ready=1, busy=0, iss_*=0.
REQ-026 rst mid-operation SHALL discard slot and scoreboard; wb_valid following rst is the environment's responsibility.
REQ-027 rst SHALL take priority over flush, accept, issue and writeback.

Configuration
REQ-028 With FPU_SB_BYPASS_EN defined, hazard SHALL use pending masked by the same-cycle wb clear, allowing accept in the writeback cycle.
REQ-029 Without FPU_SB_BYPASS_EN, hazard SHALL use registered pending only; dependent accept is one cycle after writeback.

Verification
REQ-030 Reset, then op MTC waddr=3 with iss_ready=1 -> iss_valid at cycle+1, pending=0x8 following cycle, busy=1.
REQ-031 Op writing f5, then op reading raddr2=5 -> id_ready=0 until wb_valid wb_we=1 wb_addr=5; accept same cycle with bypass, next cycle without.
REQ-032 MAX_INFLIGHT=4, iss_ready=1, 5 non-writing ops, no wb -> 4 issue, 5th held in slot with iss_valid=0 until one wb_valid.
REQ-033 Slot FULL with waddr=7, iss_ready=0, flush=1 -> slot EMPTY, pending[7]=0, inflight unchanged.
REQ-034 Issue fire, wb_valid and new accept all in one cycle -> inflight unchanged, slot stays FULL with new op.
REQ-035 rst asserted with slot FULL and inflight=2 -> next cycle pending=0, busy=0, iss_valid=0.

Source files
------------

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: single-slot FPU issue stage with a 32-entry write scoreboard
// and an in-flight op counter.
// Optional feature: define FPU_SB_BYPASS_EN to let a same-cycle writeback
// clear a scoreboard hazard, so a dependent op is accepted in the writeback
// cycle instead of one cycle later.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. Valid never depends on the matching ready in the same
// cycle, and once valid is raised the payload holds until the transfer
// (or a flush of the issue slot).
module fpu_issue_ctrl #(
   parameter int MAX_INFLIGHT = 4,
   parameter int OP_W         = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [OP_W-1:0] id_op,
   input  logic [4:0]      id_raddr1,
   input  logic [4:0]      id_raddr2,
   input  logic            id_we,
   input  logic [4:0]      id_waddr,
   output logic            id_ready,
   input  logic            flush,
   output logic            iss_valid,
   output logic [OP_W-1:0] iss_op,
   output logic [4:0]      iss_raddr1,
   output logic [4:0]      iss_raddr2,
   output logic            iss_we,
   output logic [4:0]      iss_waddr,
   input  logic            iss_ready,
   input  logic            wb_valid,
   input  logic            wb_we,
   input  logic [4:0]      wb_addr,
   output logic [31:0]     pending,
   output logic            busy,
   output logic            dbg_slot_state
);

   localparam logic       ST_EMPTY = 1'b0;
   localparam logic       ST_FULL  = 1'b1;
   localparam logic [3:0] MAX_INF  = 4'(MAX_INFLIGHT);

   logic            r_state;
   logic [OP_W-1:0] r_op;
   logic [4:0]      r_raddr1;
   logic [4:0]      r_raddr2;
   logic            r_we;
   logic [4:0]      r_waddr;
   logic [3:0]      r_inflight;
   logic [31:0]     r_pending;

   logic [31:0]     w_wb_clr;
   logic [31:0]     w_pend_chk;
   logic [31:0]     w_pend_set;
   logic [31:0]     w_flush_clr;
   logic            w_hazard;
   logic            w_iss_valid;
   logic            w_fire;
   logic            w_id_ready;
   logic            w_accept;
   logic            w_flush_drop;

   // Hazard detection, handshake and slot/scoreboard update terms
   always_comb begin
      w_wb_clr = '0;
      if (wb_valid && wb_we) w_wb_clr = 32'd1 << wb_addr;
`ifdef FPU_SB_BYPASS_EN
      w_pend_chk = r_pending & ~w_wb_clr;
`else
      w_pend_chk = r_pending;
`endif
      w_hazard     = w_pend_chk[id_raddr1] | w_pend_chk[id_raddr2] |
                     (id_we & w_pend_chk[id_waddr]);
      w_iss_valid  = (r_state == ST_FULL) && (r_inflight < MAX_INF);
      w_fire       = w_iss_valid && iss_ready;
      w_id_ready   = !w_hazard && !flush && ((r_state == ST_EMPTY) || w_fire);
      w_accept     = id_valid && w_id_ready;
      // A flush only drops an op that is not leaving this cycle
      w_flush_drop = flush && (r_state == ST_FULL) && !w_fire;
      w_pend_set   = '0;
      if (w_accept && id_we) w_pend_set = 32'd1 << id_waddr;
      w_flush_clr  = '0;
      if (w_flush_drop && r_we) w_flush_clr = 32'd1 << r_waddr;
   end

   // Issue slot state and payload registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_EMPTY;
         r_op     <= '0;
         r_raddr1 <= '0;
         r_raddr2 <= '0;
         r_we     <= 1'b0;
         r_waddr  <= '0;
      end else if (w_accept) begin
         r_state  <= ST_FULL;
         r_op     <= id_op;
         r_raddr1 <= id_raddr1;
         r_raddr2 <= id_raddr2;
         r_we     <= id_we;
         r_waddr  <= id_waddr;
      end else if (w_fire || w_flush_drop) begin
         r_state  <= ST_EMPTY;
      end
   end

   // Scoreboard: a set from a new accept wins over any clear of the same bit
   always_ff @(posedge clk) begin
      if (rst) r_pending <= '0;
      else     r_pending <= (r_pending & ~w_wb_clr & ~w_flush_clr) | w_pend_set;
   end

   // In-flight counter; a stray writeback at zero leaves it at zero
   always_ff @(posedge clk) begin
      if (rst) begin
         r_inflight <= '0;
      end else if (w_fire && !wb_valid) begin
         r_inflight <= r_inflight + 4'd1;
      end else if (!w_fire && wb_valid && (r_inflight != 4'd0)) begin
         r_inflight <= r_inflight - 4'd1;
      end
   end

   a_wb_underflow: assert property (@(posedge clk) disable iff (rst)
      !(wb_valid && (r_inflight == 4'd0)));

   assign id_ready       = w_id_ready;
   assign iss_valid      = w_iss_valid;
   assign iss_op         = r_op;
   assign iss_raddr1     = r_raddr1;
   assign iss_raddr2     = r_raddr2;
   assign iss_we         = r_we;
   assign iss_waddr      = r_waddr;
   assign pending        = r_pending;
   assign busy           = (r_state == ST_FULL) || (r_inflight != 4'd0);
   assign dbg_slot_state = r_state;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed, table-driven bench for fpu_issue_ctrl with
// hand-written sequences for the multi-cycle corner cases.
module tb_fpu_issue_ctrl;

`ifdef FPU_SB_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        id_valid;
   logic [3:0]  id_op;
   logic [4:0]  id_raddr1, id_raddr2, id_waddr;
   logic        id_we;
   logic        id_ready;
   logic        flush;
   logic        iss_valid;
   logic [3:0]  iss_op;
   logic [4:0]  iss_raddr1, iss_raddr2, iss_waddr;
   logic        iss_we;
   logic        iss_ready;
   logic        wb_valid, wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] pending;
   logic        busy;
   logic        dbg_slot_state;

   int n_checks = 0;
   int n_err    = 0;

   fpu_issue_ctrl #(.MAX_INFLIGHT(4), .OP_W(4)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_op(id_op), .id_raddr1(id_raddr1),
      .id_raddr2(id_raddr2), .id_we(id_we), .id_waddr(id_waddr),
      .id_ready(id_ready), .flush(flush),
      .iss_valid(iss_valid), .iss_op(iss_op), .iss_raddr1(iss_raddr1),
      .iss_raddr2(iss_raddr2), .iss_we(iss_we), .iss_waddr(iss_waddr),
      .iss_ready(iss_ready),
      .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr),
      .pending(pending), .busy(busy), .dbg_slot_state(dbg_slot_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        idv;
      logic [3:0]  op;
      logic [4:0]  r1, r2;
      logic        we;
      logic [4:0]  wa;
      logic        fl, ir, wbv, wbwe;
      logic [4:0]  wba;
      logic        e_rdy, e_iv, e_busy;
      logic [31:0] e_pend;
      logic [4:0]  e_wa;
      logic [3:0]  e_op;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic idv, input logic [3:0] op, input logic [4:0] r1,
                      input logic [4:0] r2, input logic we, input logic [4:0] wa,
                      input logic fl, input logic ir, input logic wbv,
                      input logic wbwe, input logic [4:0] wba,
                      input logic e_rdy, input logic e_iv, input logic e_busy,
                      input logic [31:0] e_pend, input logic [4:0] e_wa,
                      input logic [3:0] e_op);
      vec_t v;
      v.idv = idv; v.op = op; v.r1 = r1; v.r2 = r2; v.we = we; v.wa = wa;
      v.fl = fl; v.ir = ir; v.wbv = wbv; v.wbwe = wbwe; v.wba = wba;
      v.e_rdy = e_rdy; v.e_iv = e_iv; v.e_busy = e_busy; v.e_pend = e_pend;
      v.e_wa = e_wa; v.e_op = e_op;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // driver tasks
   task automatic clr();
      rst = 1'b0; id_valid = 1'b0; id_op = '0; id_raddr1 = '0; id_raddr2 = '0;
      id_we = 1'b0; id_waddr = '0; flush = 1'b0; iss_ready = 1'b0;
      wb_valid = 1'b0; wb_we = 1'b0; wb_addr = '0;
   endtask

   task automatic op(input logic [3:0] o, input logic [4:0] r1, input logic [4:0] r2,
                     input logic we, input logic [4:0] wa);
      id_valid = 1'b1; id_op = o; id_raddr1 = r1; id_raddr2 = r2;
      id_we = we; id_waddr = wa;
   endtask

   task automatic wb(input logic we, input logic [4:0] a);
      wb_valid = 1'b1; wb_we = we; wb_addr = a;
   endtask

   task automatic go();
      @(negedge clk);
      clr();
   endtask

   initial begin
      clr();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);

      //  idv op r1 r2 we wa  fl ir wbv wbwe wba  rdy iv busy pend    wa op
      add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,   1,  0, 0,   32'h0,  0, 0);
      add(1, 5, 1, 2, 1, 3,  0, 1, 0, 0, 0,   1,  0, 0,   32'h0,  0, 0);
      add(0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0,   1,  1, 1,   32'h8,  3, 5);
      add(0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0,   1,  0, 1,   32'h8,  3, 5);
      add(1, 6, 0, 0, 1, 0,  0, 1, 0, 0, 0,   1,  0, 1,   32'h8,  3, 5);
      add(1, 7, 0, 0, 0, 0,  0, 0, 0, 0, 0,   0,  1, 1,   32'h9,  0, 6);
      add(0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0,   0,  1, 1,   32'h9,  0, 6);
      add(1, 7, 1, 2, 1, 3,  0, 1, 0, 0, 0,   0,  0, 1,   32'h9,  0, 6);
      add(1, 7, 1, 2, 0, 3,  0, 1, 0, 0, 0,   1,  0, 1,   32'h9,  0, 6);
      add(0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 3,   0,  1, 1,   32'h9,  3, 7);
      add(1, 8, 1, 2, 1, 4,  0, 1, 1, 1, 4,   1,  1, 1,   32'h1,  3, 7);
      add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,   0,  1, 1,   32'h11, 4, 8);
      add(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,   0,  1, 1,   32'h11, 4, 8);
      add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,   0,  0, 1,   32'h1,  4, 8);
      add(0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0,   BYP, 0, 1,  32'h1,  4, 8);
      add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,   1,  0, 0,   32'h0,  4, 8);

      foreach (vq[i]) begin
         @(negedge clk);
         clr();
         id_valid = vq[i].idv; id_op = vq[i].op; id_raddr1 = vq[i].r1;
         id_raddr2 = vq[i].r2; id_we = vq[i].we; id_waddr = vq[i].wa;
         flush = vq[i].fl; iss_ready = vq[i].ir; wb_valid = vq[i].wbv;
         wb_we = vq[i].wbwe; wb_addr = vq[i].wba;
         #1;
         chk($sformatf("vec%0d.id_ready", i), 32'(id_ready), 32'(vq[i].e_rdy));
         chk($sformatf("vec%0d.iss_valid", i), 32'(iss_valid), 32'(vq[i].e_iv));
         chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(vq[i].e_busy));
         chk($sformatf("vec%0d.pending", i), pending, vq[i].e_pend);
         chk($sformatf("vec%0d.iss_waddr", i), 32'(iss_waddr), 32'(vq[i].e_wa));
         chk($sformatf("vec%0d.iss_op", i), 32'(iss_op), 32'(vq[i].e_op));
      end

      // RAW on f5 resolved by a writeback
      go(); op(1, 0, 0, 1, 5); iss_ready = 1; #1;
      chk("raw.first_accept", 32'(id_ready), 32'd1);
      go(); op(2, 0, 5, 0, 0); iss_ready = 1; #1;
      chk("raw.blocked0", 32'(id_ready), 32'd0);
      chk("raw.writer_issue", 32'(iss_valid), 32'd1);
      go(); op(2, 0, 5, 0, 0); iss_ready = 1; #1;
      chk("raw.blocked1", 32'(id_ready), 32'd0);
      go(); op(2, 0, 5, 0, 0); iss_ready = 1; wb(1, 5); #1;
      chk("raw.wb_cycle_ready", 32'(id_ready), 32'(BYP));
      go(); op(2, 0, 5, 0, 0); id_valid = !BYP; iss_ready = 1; #1;
      chk("raw.after_wb_ready", 32'(id_ready), 32'd1);
      chk("raw.after_wb_iv", 32'(iss_valid), 32'(BYP));
      go(); iss_ready = 1; #1;
      chk("raw.late_iv", 32'(iss_valid), 32'(!BYP));
      chk("raw.iss_op", 32'(iss_op), 32'd2);
      chk("raw.iss_raddr2", 32'(iss_raddr2), 32'd5);
      go(); wb(0, 0); #1;
      chk("raw.busy_before_wb", 32'(busy), 32'd1);
      go(); #1;
      chk("raw.busy_idle", 32'(busy), 32'd0);
      chk("raw.pending_idle", pending, 32'd0);

      // In-flight limit: fifth non-writing op waits in the slot
      for (int i = 0; i < 5; i++) begin
         go(); op(4'(i + 1), 0, 0, 0, 0); iss_ready = 1; #1;
         chk($sformatf("lim.accept%0d", i), 32'(id_ready), 32'd1);
      end
      go(); iss_ready = 1; #1;
      chk("lim.held_iv", 32'(iss_valid), 32'd0);
      chk("lim.held_op", 32'(iss_op), 32'd5);
      chk("lim.held_rdy", 32'(id_ready), 32'd0);
      go(); iss_ready = 1; #1;
      chk("lim.held_iv2", 32'(iss_valid), 32'd0);
      go(); iss_ready = 1; wb(0, 0); #1;
      chk("lim.wb_cycle_iv", 32'(iss_valid), 32'd0);
      go(); iss_ready = 1; #1;
      chk("lim.released_iv", 32'(iss_valid), 32'd1);
      for (int i = 0; i < 4; i++) begin
         go(); wb(0, 0);
      end
      go(); #1;
      chk("lim.drained_busy", 32'(busy), 32'd0);

      // Flush in the cycle the slot issues keeps the issued op
      go(); op(5, 0, 0, 1, 9); iss_ready = 1;
      go(); flush = 1; iss_ready = 1; #1;
      chk("flfire.iv", 32'(iss_valid), 32'd1);
      go(); #1;
      chk("flfire.busy", 32'(busy), 32'd1);
      chk("flfire.pending", pending, 32'h200);
      go(); wb(1, 9);
      go(); #1;
      chk("flfire.idle_busy", 32'(busy), 32'd0);
      chk("flfire.idle_pending", pending, 32'd0);

      // Reset with slot FULL and two ops in flight
      go(); op(3, 0, 0, 1, 6); iss_ready = 1;
      go(); op(4, 0, 0, 1, 7); iss_ready = 1;
      go(); op(9, 0, 0, 0, 0); iss_ready = 1;
      go(); #1;
      chk("rst.pre_iv", 32'(iss_valid), 32'd1);
      chk("rst.pre_pending", pending, 32'hC0);
      go(); rst = 1; op(10, 1, 1, 1, 1); iss_ready = 1; wb(1, 6);
      go(); #1;
      chk("rst.pending", pending, 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.iv", 32'(iss_valid), 32'd0);
      chk("rst.rdy", 32'(id_ready), 32'd1);
      chk("rst.iss_op", 32'(iss_op), 32'd0);
      chk("rst.iss_waddr", 32'(iss_waddr), 32'd0);
      chk("rst.iss_raddr1", 32'(iss_raddr1), 32'd0);
      chk("rst.iss_raddr2", 32'(iss_raddr2), 32'd0);
      chk("rst.iss_we", 32'(iss_we), 32'd0);
      chk("rst.slot_state", 32'(dbg_slot_state), 32'd0);

      // final report
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
